// File: rtl/nn_ctrl_pkg.sv
// Shared types and default sizing for the inference sequencer.
// The defaults match the network this controller feeds.
package nn_ctrl_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      FIRE = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int NN_NUM_INPUTS  = 784;
   localparam int NN_DATA_WIDTH  = 16;
   localparam int NN_NUM_OUTPUTS = 10;
   localparam int NN_TIMEOUT     = 4096;

endpackage

// File: rtl/nn_frame_packer.sv
// Packs accepted pixels into the flat network input vector and detects
// frame boundaries: frame_done is a same-cycle strobe, frame_err a registered pulse.
module nn_frame_packer
   import nn_ctrl_pkg::*;
#(
   parameter int numInputs = NN_NUM_INPUTS,
   parameter int dataWidth = NN_DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [dataWidth-1:0]           pix_data,
   input  logic                           pix_xfer,
   input  logic                           pix_last,
   output logic [dataWidth*numInputs-1:0] frame_vec,
   output logic                           frame_done,
   output logic                           frame_err
);

   localparam int ptrWidth = $clog2(numInputs);
   localparam logic [ptrWidth-1:0] lastSlot = ptrWidth'(numInputs - 1);

   logic [ptrWidth-1:0] wr_ptr_reg;
   logic                frame_err_reg;
   logic                at_last;

   assign at_last    = (wr_ptr_reg == lastSlot);
   assign frame_done = pix_xfer & at_last;
   assign frame_err  = frame_err_reg;

   // A frame is malformed if pixLast comes early or is missing on the final slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg    <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         frame_err_reg <= pix_xfer & (at_last ? ~pix_last : pix_last);
         if (pix_xfer) begin
            if (at_last || pix_last)
               wr_ptr_reg <= '0;
            else
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < numInputs; gi++) begin : g_slot
         logic [dataWidth-1:0] slot_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               slot_reg <= '0;
            else if (pix_xfer && (wr_ptr_reg == ptrWidth'(gi)))
               slot_reg <= pix_data;
         end

         assign frame_vec[gi*dataWidth +: dataWidth] = slot_reg;
      end
   endgenerate

endmodule

// File: rtl/nn_inference_ctrl.sv
// Frame loader and single-inference sequencer in front of the network top.
// Loads a frame, pulses NNvalid, waits for hardmax under a timeout, holds the result.
module nn_inference_ctrl
   import nn_ctrl_pkg::*;
#(
   parameter int numInputs     = NN_NUM_INPUTS,
   parameter int dataWidth     = NN_DATA_WIDTH,
   parameter int numOutputs    = NN_NUM_OUTPUTS,
   parameter int timeoutCycles = NN_TIMEOUT,
   localparam int idxWidth     = $clog2(numOutputs)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [dataWidth-1:0]           pixIn,
   input  logic                           pixValid,
   input  logic                           pixLast,
   output logic                           pixReady,
   output logic [dataWidth*numInputs-1:0] NNin,
   output logic                           NNvalid,
   input  logic [idxWidth-1:0]            maxIndex,
   input  logic [dataWidth-1:0]           maxValue,
   input  logic                           maxValid,
   output logic [idxWidth-1:0]            resIndex,
   output logic [dataWidth-1:0]           resValue,
   output logic                           resValid,
   input  logic                           resReady,
   output logic                           busy,
   output logic                           frameErr,
   output logic                           timeoutErr
);

   localparam int tmrWidth = $clog2(timeoutCycles);
   localparam logic [tmrWidth-1:0] tmrLast = tmrWidth'(timeoutCycles - 1);

   state_t                state_reg, state_next;
   logic [tmrWidth-1:0]   timer_reg;
   logic                  pix_ready_reg, nn_valid_reg, res_valid_reg;
   logic                  busy_reg, timeout_err_reg;
   logic [idxWidth-1:0]   res_index_reg;
   logic [dataWidth-1:0]  res_value_reg;
   logic                  pix_xfer, frame_done, timeout_hit, capture;

   assign pix_xfer = pixValid & pix_ready_reg;

   nn_frame_packer #(
      .numInputs (numInputs),
      .dataWidth (dataWidth)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .pix_data   (pixIn),
      .pix_xfer   (pix_xfer),
      .pix_last   (pixLast),
      .frame_vec  (NNin),
      .frame_done (frame_done),
      .frame_err  (frameErr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_reg <= LOAD;
      else
         state_reg <= state_next;
   end

   // A result strobe on the final timer cycle takes priority over the timeout.
   always_comb begin
      state_next  = state_reg;
      timeout_hit = 1'b0;
      capture     = 1'b0;
      case (state_reg)
         LOAD: if (frame_done) state_next = FIRE;
         FIRE: state_next = WAIT;
         WAIT: begin
            if (maxValid) begin
               capture    = 1'b1;
               state_next = DONE;
            end else if (timer_reg == tmrLast) begin
               timeout_hit = 1'b1;
               state_next  = LOAD;
            end
         end
         DONE: if (resReady) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   // Outputs are derived from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_reg       <= '0;
         pix_ready_reg   <= 1'b0;
         nn_valid_reg    <= 1'b0;
         res_valid_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
         res_index_reg   <= '0;
         res_value_reg   <= '0;
      end else begin
         pix_ready_reg   <= (state_next == LOAD);
         nn_valid_reg    <= (state_next == FIRE);
         res_valid_reg   <= (state_next == DONE);
         busy_reg        <= (state_next != LOAD);
         timeout_err_reg <= timeout_hit;
         if (state_next == FIRE)
            timer_reg <= '0;
         else if ((state_reg == FIRE) || (state_reg == WAIT))
            timer_reg <= timer_reg + 1'b1;
         if (capture) begin
            res_index_reg <= maxIndex;
            res_value_reg <= maxValue;
         end
      end
   end

   assign pixReady   = pix_ready_reg;
   assign NNvalid    = nn_valid_reg;
   assign resValid   = res_valid_reg;
   assign resIndex   = res_index_reg;
   assign resValue   = res_value_reg;
   assign busy       = busy_reg;
   assign timeoutErr = timeout_err_reg;

endmodule
